// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative 32-bit shifter for SLL/SRL/SRA, one bit per clock
// under a start/done handshake. Stands in for a combinational barrel shifter
// next to the EX-stage ALU; the pipeline stalls while busy is high.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   shift request, sampled only while idle
//   op       in   MIPS funct[1:0]: 00 SLL, 10 SRL, 11 SRA, 01 pass-through
//   shamt    in   shift amount 0..31
//   data_in  in   operand (rt)
//   result   out  shifted value, valid with done, held until the next start
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//
// Configuration macro:
//   SEQ_SHIFT_FAST4_EN  when defined, steps of 4 bits are taken while the
//                       remaining count is >= 4 (same results, lower latency).
module seq_shift_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data_in,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_RSV = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Single-position shift; the reserved op never reaches here with cnt != 0.
  function automatic logic [DW-1:0] shift1(input logic [DW-1:0] a, input logic [1:0] o);
    case (o)
      OP_SLL:  shift1 = {a[DW-2:0], 1'b0};
      OP_SRL:  shift1 = {1'b0, a[DW-1:1]};
      OP_SRA:  shift1 = {a[DW-1], a[DW-1:1]};
      default: shift1 = a;
    endcase
  endfunction

`ifdef SEQ_SHIFT_FAST4_EN
  // Four-position shift used while at least four steps remain.
  function automatic logic [DW-1:0] shift4(input logic [DW-1:0] a, input logic [1:0] o);
    case (o)
      OP_SLL:  shift4 = {a[DW-5:0], 4'b0000};
      OP_SRL:  shift4 = {4'b0000, a[DW-1:4]};
      OP_SRA:  shift4 = {{4{a[DW-1]}}, a[DW-1:4]};
      default: shift4 = a;
    endcase
  endfunction
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = data_in;
          cnt_d   = (op == OP_RSV) ? '0 : shamt;
          op_d    = op;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
`ifdef SEQ_SHIFT_FAST4_EN
          if (cnt_q >= SW'(4)) begin
            acc_d = shift4(acc_q, op_q);
            cnt_d = cnt_q - SW'(4);
          end else begin
            acc_d = shift1(acc_q, op_q);
            cnt_d = cnt_q - SW'(1);
          end
`else
          acc_d = shift1(acc_q, op_q);
          cnt_d = cnt_q - SW'(1);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Flags are registered from the next state so they track state_q exactly.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign result = acc_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: expected result/latency pairs are
// queued when a start is accepted and compared when done pulses.
module tb_seq_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   done_cnt = 0;

  seq_shift_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [4:0] n,
                                            input logic [31:0] d);
    case (o)
      2'b00:   model_res = d << n;
      2'b10:   model_res = d >> n;
      2'b11:   model_res = 32'($signed(d) >>> n);
      default: model_res = d;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [4:0] n);
    int k;
    k = (o == 2'b01) ? 0 : int'(n);
`ifdef SEQ_SHIFT_FAST4_EN
    model_lat = k / 4 + k % 4 + 1;
`else
    model_lat = k + 1;
`endif
  endfunction

  // Monitor: compare every done pulse against the head of the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.tag, "_result"}, result, e.res);
          check({e.tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  // Issue one operation; the expectation is queued right after the accept edge.
  task automatic issue(input string tag, input logic [1:0] o, input logic [4:0] n,
                       input logic [31:0] d, input bit push);
    exp_t e;
    wait_idle(tag);
    start = 1'b1; op = o; shamt = n; data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.tag = tag; e.res = model_res(o, n, d); e.lat = model_lat(o, n); e.t0 = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [4:0] n,
                     input logic [31:0] d);
    issue(tag, o, n, d, 1'b1);
    wait_done(tag);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; shamt = '0; data_in = '0;
    #12;
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: everything stays quiet.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_result", result, 32'd0);
    end

    run("sll65_2", 2'b00, 5'd2, 32'd65);
    check("sll65_2_value", result, 32'h0000_0104);
    run("sra_min_31", 2'b11, 5'd31, 32'h8000_0000);
    check("sra_min_31_value", result, 32'hFFFF_FFFF);
    run("srl234_0", 2'b10, 5'd0, 32'd234);
    run("rsv_op", 2'b01, 5'd9, 32'h1234_5678);
    check("rsv_op_value", result, 32'h1234_5678);

    // Result holds through IDLE after done.
    repeat (3) @(negedge clk);
    check("hold_result", result, 32'h1234_5678);
    check("hold_busy", 32'(busy), 32'd0);

    // Re-pulsed start during SHIFT and DONE must be ignored.
    dc = done_cnt;
    issue("srl_repulse", 2'b10, 5'd4, 32'hF000_0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b1; op = 2'b00; shamt = 5'd3; data_in = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("repulse_done_count", 32'(done_cnt - dc), 32'd1);
    check("repulse_result", result, 32'h0F00_0000);
    check("repulse_busy", 32'(busy), 32'd0);

    // Reset in the 5th SHIFT cycle aborts with no done.
    dc = done_cnt;
    issue("sll_abort", 2'b00, 5'd20, 32'hFFFF_FFFF, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dc), 32'd0);
    run("sll1_31", 2'b00, 5'd31, 32'd1);
    check("sll1_31_value", result, 32'h8000_0000);

    // Random operations through the scoreboard.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] ro;
      ro = 2'($urandom_range(0, 3));
      run("rand", ro, 5'($urandom_range(0, 31)), $urandom());
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
